// File: rtl/t_ff_counter.sv
// rtl/t_ff_counter.sv - up/down modulo counter built from per-bit toggle stages
module t_ff_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear_b,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Enable,
  input  logic             Up,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrapped
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_next;
  logic             at_last;
  logic             at_zero;
  logic             wrap;
  logic             wrap_next;

  assign at_last  = (Q == LAST);
  assign at_zero  = (Q == '0);
  assign wrap     = Enable & (Up ? at_last : at_zero);
  assign TC       = wrap;
  assign load_val = ({1'b0, D} < MOD_EXT) ? D : LAST;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); the carry walks upward.
  always_comb begin
    logic carry;
    toggle = '0;
    carry  = Enable;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = carry;
      carry     = carry & (Up ? Q[i] : ~Q[i]);
    end
  end

  // Wrap overrides the toggle vector so non-power-of-two moduli stay in range.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (!Clear_b) begin
      q_next = '0;
    end else if (Load) begin
      q_next = load_val;
    end else if (wrap) begin
      q_next    = Up ? '0 : LAST;
      wrap_next = 1'b1;
    end else begin
      q_next = Q ^ toggle;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Q       <= '0;
      Wrapped <= 1'b0;
    end else begin
      Q       <= q_next;
      Wrapped <= wrap_next;
    end
  end

endmodule

// File: tb/tb_t_ff_counter.sv
// tb/tb_t_ff_counter.sv - directed vector bench for t_ff_counter
module tb_t_ff_counter;

  typedef struct {
    logic       clear_b;
    logic       load;
    logic [3:0] d;
    logic       enable;
    logic       up;
    logic [3:0] q;
    logic       tc;
    logic       wrapped;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  logic       a_clear_b, a_load, a_en, a_up, a_tc, a_wr;
  logic [3:0] a_d, a_q;
  logic       b_clear_b, b_load, b_en, b_up, b_tc, b_wr;
  logic [3:0] b_d, b_q;
  logic       m_clear_b, m_load, m_en, m_up, m_tc, m_wr;
  logic [1:0] m_d, m_q;
  logic       c_clear_b, c_load, c_en, c_up;
  logic [3:0] c_d, lo_q, hi_q;
  logic       lo_tc, lo_wr, hi_tc, hi_wr;

  always #5 Clock = ~Clock;

  t_ff_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .Clock(Clock), .Reset(Reset), .Clear_b(a_clear_b), .Load(a_load), .D(a_d),
    .Enable(a_en), .Up(a_up), .Q(a_q), .TC(a_tc), .Wrapped(a_wr));

  t_ff_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
    .Clock(Clock), .Reset(Reset), .Clear_b(b_clear_b), .Load(b_load), .D(b_d),
    .Enable(b_en), .Up(b_up), .Q(b_q), .TC(b_tc), .Wrapped(b_wr));

  t_ff_counter #(.WIDTH(2), .MODULUS(2)) dut_m (
    .Clock(Clock), .Reset(Reset), .Clear_b(m_clear_b), .Load(m_load), .D(m_d),
    .Enable(m_en), .Up(m_up), .Q(m_q), .TC(m_tc), .Wrapped(m_wr));

  t_ff_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .Clock(Clock), .Reset(Reset), .Clear_b(c_clear_b), .Load(c_load), .D(c_d),
    .Enable(c_en), .Up(c_up), .Q(lo_q), .TC(lo_tc), .Wrapped(lo_wr));

  t_ff_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .Clock(Clock), .Reset(Reset), .Clear_b(c_clear_b), .Load(c_load), .D(c_d),
    .Enable(lo_tc), .Up(c_up), .Q(hi_q), .TC(hi_tc), .Wrapped(hi_wr));

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic l, input logic [3:0] d, input logic e,
                     input logic u, input logic [3:0] q, input logic tc, input logic w);
    vec_t v;
    v.clear_b = c; v.load = l; v.d = d; v.enable = e; v.up = u;
    v.q = q; v.tc = tc; v.wrapped = w;
    vq.push_back(v);
  endtask

  task automatic set_a(input logic c, input logic l, input logic [3:0] d,
                       input logic e, input logic u);
    a_clear_b = c; a_load = l; a_d = d; a_en = e; a_up = u;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int wraps;
    int cnt;
    set_a(1, 0, 0, 0, 1);
    b_clear_b = 1; b_load = 0; b_d = 0; b_en = 0; b_up = 1;
    m_clear_b = 1; m_load = 0; m_d = 0; m_en = 0; m_up = 1;
    c_clear_b = 1; c_load = 0; c_d = 0; c_en = 0; c_up = 1;

    // Reset rises before the first clock edge: outputs must clear asynchronously.
    #2 Reset = 1'b1;
    #1;
    check("rst_a_q", 0, 16'(a_q), 16'd0);
    check("rst_a_wr", 0, 16'(a_wr), 16'd0);
    check("rst_b_q", 0, 16'(b_q), 16'd0);
    check("rst_m_q", 0, 16'(m_q), 16'd0);
    check("rst_cas_q", 0, 16'({hi_q, lo_q}), 16'h00);
    tick();
    tick();
    Reset = 1'b0;

    // clear_b load d en up | q tc wrapped  (MODULUS=10)
    for (int i = 0; i < 9; i++) add(1, 0, 0, 1, 1, 4'(i + 1), (i == 8), 0);
    add(1, 0, 0,  1, 1, 0, 0, 1);
    add(1, 0, 0,  1, 1, 1, 0, 0);
    add(1, 0, 0,  1, 1, 2, 0, 0);
    add(1, 1, 2,  0, 0, 2, 0, 0);
    add(1, 0, 0,  1, 0, 1, 0, 0);
    add(1, 0, 0,  1, 0, 0, 1, 0);
    add(1, 0, 0,  1, 0, 9, 0, 1);
    add(1, 0, 0,  1, 1, 0, 0, 1);
    add(1, 1, 13, 1, 1, 9, 1, 0);
    add(0, 1, 5,  1, 1, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 1, 0);
    add(1, 1, 9,  0, 1, 9, 0, 0);
    add(1, 1, 10, 0, 1, 9, 0, 0);
    add(1, 1, 4,  0, 1, 4, 0, 0);
    add(1, 0, 0,  0, 1, 4, 0, 0);
    add(1, 1, 15, 1, 0, 9, 0, 0);
    add(1, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 0,  1, 1, 0, 0, 0);
    add(1, 0, 0,  1, 0, 9, 0, 1);

    foreach (vq[i]) begin
      set_a(vq[i].clear_b, vq[i].load, vq[i].d, vq[i].enable, vq[i].up);
      tick();
      check("vec_q", i, 16'(a_q), 16'(vq[i].q));
      check("vec_tc", i, 16'(a_tc), 16'(vq[i].tc));
      check("vec_wrapped", i, 16'(a_wr), 16'(vq[i].wrapped));
    end

    // Asynchronous reset in the middle of a count.
    set_a(0, 0, 0, 0, 1);
    tick();
    check("ar_clear", 0, 16'(a_q), 16'd0);
    set_a(1, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("ar_count", i, 16'(a_q), 16'(i + 1));
    end
    #3 Reset = 1'b1;
    #1;
    check("ar_async_q", 0, 16'(a_q), 16'd0);
    check("ar_async_wr", 0, 16'(a_wr), 16'd0);
    tick();
    check("ar_hold_q", 0, 16'(a_q), 16'd0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_resume", i, 16'(a_q), 16'(i + 1));
    end

    // Reset while a wrap pulse is showing cancels it.
    set_a(1, 1, 9, 0, 1);
    tick();
    set_a(1, 0, 0, 1, 1);
    tick();
    check("arw_q", 0, 16'(a_q), 16'd0);
    check("arw_pulse", 0, 16'(a_wr), 16'd1);
    #3 Reset = 1'b1;
    #1;
    check("arw_cancel", 0, 16'(a_wr), 16'd0);
    #2 Reset = 1'b0;
    tick();
    check("arw_after_q", 0, 16'(a_q), 16'd1);
    check("arw_after_wr", 0, 16'(a_wr), 16'd0);
    set_a(1, 0, 0, 0, 1);

    // Full binary range: natural and forced wrap must agree.
    b_en = 1; b_up = 1;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (b_wr) wraps++;
      check("bin_q", i, 16'(b_q), 16'((i + 1) % 16));
      check("bin_tc", i, 16'(b_tc), 16'(((i + 1) % 16) == 15));
    end
    check("bin_wraps", 0, 16'(wraps), 16'd1);
    b_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bin_hold_q", i, 16'(b_q), 16'd0);
      check("bin_hold_tc", i, 16'(b_tc), 16'd0);
      check("bin_hold_wr", i, 16'(b_wr), 16'd0);
    end

    // MODULUS=2: saturating load and back-to-back wraps via direction changes.
    m_load = 1; m_d = 2'd3;
    tick();
    check("m2_load", 0, 16'(m_q), 16'd1);
    m_load = 0; m_en = 1; m_up = 1;
    tick();
    check("m2_q", 0, 16'(m_q), 16'd0);
    check("m2_wr", 0, 16'(m_wr), 16'd1);
    m_up = 0;
    tick();
    check("m2_q", 1, 16'(m_q), 16'd1);
    check("m2_wr", 1, 16'(m_wr), 16'd1);
    check("m2_tc", 1, 16'(m_tc), 16'd0);
    m_up = 1;
    tick();
    check("m2_q", 2, 16'(m_q), 16'd0);
    check("m2_wr", 2, 16'(m_wr), 16'd1);
    m_en = 0;
    tick();
    check("m2_idle_wr", 0, 16'(m_wr), 16'd0);

    // Two-stage decimal cascade through TC.
    c_en = 1; c_up = 1;
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cnt = (i + 1) % 100;
      if (hi_wr) wraps++;
      check("cas_q", i, 16'({hi_q, lo_q}), 16'({4'(cnt / 10), 4'(cnt % 10)}));
      if (i == 98) check("cas_hi_tc", i, 16'(hi_tc), 16'd1);
    end
    check("cas_hi_wraps", 0, 16'(wraps), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
